// File: rtl/hint_encoder_if.sv
// ---------------------------------------------------------------------------
// hint_encoder_if
// Groups the hint beat stream and the dword register-write bus of the
// hint encoder into one bundle.
//   hint_valid  : hint beat valid (producer -> encoder)
//   hint        : COEF_PER_CYC hint bits, lane i = coefficient beat*COEF_PER_CYC+i
//   hint_ready  : encoder accepts a beat when hint_valid & hint_ready
//   reg_wren    : dword write strobe (encoder -> register file)
//   reg_wr_addr : dword address of the write
//   reg_wrdata  : packed stream bytes, byte j at bits [8j+7:8j]
// The slave modport is the encoder side; the master modport is the
// producer / register-file side.
// ---------------------------------------------------------------------------
interface hint_encoder_if #(
  parameter int COEF_PER_CYC = 4,
  parameter int REG_ADDR_W   = 6
);
  logic                    hint_valid;
  logic [COEF_PER_CYC-1:0] hint;
  logic                    hint_ready;
  logic                    reg_wren;
  logic [REG_ADDR_W-1:0]   reg_wr_addr;
  logic [31:0]             reg_wrdata;

  modport master (
    output hint_valid,
    output hint,
    input  hint_ready,
    input  reg_wren,
    input  reg_wr_addr,
    input  reg_wrdata
  );

  modport slave (
    input  hint_valid,
    input  hint,
    output hint_ready,
    output reg_wren,
    output reg_wr_addr,
    output reg_wrdata
  );
endinterface

// File: rtl/hint_encoder.sv
// ---------------------------------------------------------------------------
// hint_encoder
// Packs ML-DSA hint vectors into the signature hint byte stream:
// set-hint indices per polynomial, zero fill up to OMEGA, then one
// cumulative hint count per polynomial, zero-padded to whole dwords and
// written out as consecutive 32-bit register writes.
// Ports:
//   clk        : clock
//   reset_n    : asynchronous active-low reset
//   zeroize    : synchronous clear back to the reset state
//   start      : start pulse, honoured only while idle
//   cfg_k      : polynomial count, latched on start
//   cfg_omega  : hint budget OMEGA, latched on start
//   bus        : hint beat stream in, dword register writes out
//   invalid_h  : sticky, total hints exceeded OMEGA
//   done       : single-cycle completion pulse
// ---------------------------------------------------------------------------
module hint_encoder #(
  parameter int MLDSA_N      = 256,
  parameter int COEF_PER_CYC = 4,
  parameter int K_MAX        = 8,
  parameter int REG_ADDR_W   = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          zeroize,
  input  logic          start,
  input  logic [3:0]    cfg_k,
  input  logic [6:0]    cfg_omega,
  hint_encoder_if.slave bus,
  output logic          invalid_h,
  output logic          done
);

  localparam int BEATS  = MLDSA_N / COEF_PER_CYC;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, TAIL, DONE} state_t;

  state_t                state;
  logic [3:0]            k_q;
  logic [6:0]            omega_q;
  logic [3:0]            poly_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [11:0]           total_q;
  logic [9:0]            pos_q;
  logic [3:0]            cnt_q;
  logic [55:0]           buf_q;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [7:0]            rec_q [K_MAX];

  logic                  ready_q;
  logic                  wren_q;
  logic [REG_ADDR_W-1:0] wr_addr_q;
  logic [31:0]           wrdata_q;

  logic                  accept;
  logic                  emit;
  logic [3:0]            base;
  logic [3:0]            n;
  logic [3:0]            slot;
  logic [7:0]            val;
  logic [9:0]            q;
  logic [9:0]            rel;
  logic [9:0]            padded;
  logic [11:0]           run;
  logic [55:0]           nbuf;
  logic                  last_beat;
  logic                  last_poly;

  assign bus.hint_ready  = ready_q;
  assign bus.reg_wren    = wren_q;
  assign bus.reg_wr_addr = wr_addr_q;
  assign bus.reg_wrdata  = wrdata_q;

  // Byte buffer datapath. The oldest four bytes leave as a dword whenever at
  // least four are pending, so at most three remain and a full beat (or four
  // tail bytes) always fits behind them within seven bytes. Index bytes are
  // only kept while the running count is below OMEGA; the count itself keeps
  // going so the invalid flag and the per-polynomial totals stay exact.
  always_comb begin
    accept = ready_q & bus.hint_valid;
    emit   = (cnt_q >= 4'd4);
    base   = emit ? (cnt_q - 4'd4) : cnt_q;
    nbuf   = emit ? {32'd0, buf_q[55:32]} : buf_q;
    padded = (10'(omega_q) + 10'(k_q) + 10'd3) & ~10'd3;
    run    = total_q;
    n      = '0;
    slot   = '0;
    val    = '0;
    q      = '0;
    rel    = '0;

    if (accept) begin
      for (int i = 0; i < COEF_PER_CYC; i++) begin
        if (bus.hint[i]) begin
          if (run < 12'(omega_q)) begin
            slot = base + n;
            val  = 8'(int'(beat_q) * COEF_PER_CYC + i);
            for (int b = 0; b < 7; b++) begin
              if (slot == 4'(b)) nbuf[8*b +: 8] = val;
            end
            n = n + 4'd1;
          end
          run = run + 12'd1;
        end
      end
    end

    // Tail bytes: zero fill below OMEGA, recorded counts after it, zero pad
    // beyond OMEGA+k up to the dword boundary.
    if (state == TAIL) begin
      for (int j = 0; j < 4; j++) begin
        q = pos_q + 10'(j);
        if (q < padded) begin
          val = '0;
          rel = q - 10'(omega_q);
          if (q >= 10'(omega_q)) begin
            for (int p = 0; p < K_MAX; p++) begin
              if (rel == 10'(p) && 4'(p) < k_q) val = rec_q[p];
            end
          end
          slot = base + n;
          for (int b = 0; b < 7; b++) begin
            if (slot == 4'(b)) nbuf[8*b +: 8] = val;
          end
          n = n + 4'd1;
        end
      end
    end

    last_beat = accept && (beat_q == BEAT_W'(BEATS - 1));
    last_poly = (poly_q == k_q - 4'd1);
  end

  // Control FSM plus all registered state and outputs. Zeroize behaves like
  // reset so an aborted run leaves nothing pending in the buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      k_q       <= '0;
      omega_q   <= '0;
      poly_q    <= '0;
      beat_q    <= '0;
      total_q   <= '0;
      pos_q     <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      addr_q    <= '0;
      for (int p = 0; p < K_MAX; p++) rec_q[p] <= '0;
      ready_q   <= 1'b0;
      wren_q    <= 1'b0;
      wr_addr_q <= '0;
      wrdata_q  <= '0;
      invalid_h <= 1'b0;
      done      <= 1'b0;
    end else if (zeroize) begin
      state     <= IDLE;
      k_q       <= '0;
      omega_q   <= '0;
      poly_q    <= '0;
      beat_q    <= '0;
      total_q   <= '0;
      pos_q     <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      addr_q    <= '0;
      for (int p = 0; p < K_MAX; p++) rec_q[p] <= '0;
      ready_q   <= 1'b0;
      wren_q    <= 1'b0;
      wr_addr_q <= '0;
      wrdata_q  <= '0;
      invalid_h <= 1'b0;
      done      <= 1'b0;
    end else begin
      wren_q   <= emit;
      wrdata_q <= emit ? buf_q[31:0] : 32'd0;
      if (emit) begin
        wr_addr_q <= addr_q;
        addr_q    <= addr_q + 1'b1;
      end
      buf_q   <= nbuf;
      cnt_q   <= base + n;
      pos_q   <= pos_q + 10'(n);
      total_q <= run;
      done    <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            k_q       <= cfg_k;
            omega_q   <= cfg_omega;
            poly_q    <= '0;
            beat_q    <= '0;
            total_q   <= '0;
            pos_q     <= '0;
            cnt_q     <= '0;
            buf_q     <= '0;
            addr_q    <= '0;
            for (int p = 0; p < K_MAX; p++) rec_q[p] <= '0;
            invalid_h <= 1'b0;
            ready_q   <= 1'b1;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            beat_q <= beat_q + 1'b1;
            if (run > 12'(omega_q)) invalid_h <= 1'b1;
            if (last_beat) begin
              beat_q <= '0;
              for (int p = 0; p < K_MAX; p++) begin
                if (4'(p) == poly_q) rec_q[p] <= (run > 12'd255) ? 8'hFF : run[7:0];
              end
              if (last_poly) begin
                ready_q <= 1'b0;
                state   <= TAIL;
              end else begin
                poly_q <= poly_q + 4'd1;
              end
            end
          end
        end
        TAIL: begin
          // All bytes generated and the last dword already handed out.
          if (pos_q == padded && cnt_q == 4'd0) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hint_encoder.md
HINT_ENCODER -- requirements
Module: hint_encoder

Interface
REQ-001 SHALL have parameter MLDSA_N, default 256, coefficients per polynomial.
REQ-002 SHALL have parameter COEF_PER_CYC, default 4, hint lanes per beat; legal values 1, 2, 4.
REQ-003 SHALL have parameter K_MAX, default 8, maximum polynomial count.
REQ-004 SHALL have parameter REG_ADDR_W, default 6, dword address width.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port zeroize, input, 1, synchronous clear to reset state.
REQ-008 SHALL have port start, input, 1, single-cycle start pulse; sampled only in IDLE.
REQ-009 SHALL have port cfg_k, input, 4, polynomial count; legal 1..K_MAX; latched on start.
REQ-010 SHALL have port cfg_omega, input, 7, hint budget OMEGA; latched on start; cfg_omega+cfg_k SHALL be at most 4*2^REG_ADDR_W.
REQ-011 SHALL have port hint_valid, input, 1, hint beat valid.
REQ-012 SHALL have port hint, input, COEF_PER_CYC, hint bits; lane i is coefficient beat*COEF_PER_CYC+i.
REQ-013 SHALL have port hint_ready, output, 1, beat accepted when hint_valid & hint_ready.
REQ-014 SHALL have port reg_wren, output, 1, dword write strobe.
REQ-015 SHALL have port reg_wr_addr, output, REG_ADDR_W, dword address, starting at 0.
REQ-016 SHALL have port reg_wrdata, output, 32, packed bytes; byte j of the dword at bits [8j+7:8j].
REQ-017 SHALL have port invalid_h, output, 1, sticky flag set when total hints exceed OMEGA.
REQ-018 SHALL have port done, output, 1, single-cycle completion pulse.

Function
REQ-019 SHALL implement FSM states IDLE, ACCUM, TAIL, DONE.
REQ-020 SHALL move IDLE->ACCUM on start, latching cfg_k and cfg_omega and clearing counters, buffer, addr, invalid_h.
REQ-021 SHALL drive hint_ready=1 only in ACCUM; no backpressure inside ACCUM.
REQ-022 SHALL count beats per polynomial; after MLDSA_N/COEF_PER_CYC accepted beats, close the polynomial and record its cumulative hint count.
REQ-023 SHALL move ACCUM->TAIL after the last beat of polynomial cfg_k-1.
REQ-024 SHALL define the output byte stream h[0..cfg_omega+cfg_k-1] as: in-poly indices (8-bit, ascending lane order) of set hints, in polynomial order; then zeros up to byte cfg_omega-1; then h[cfg_omega+p] = cumulative count after polynomial p, saturated to 255.
REQ-025 SHALL zero-pad the stream to a dword boundary and emit exactly ceil((cfg_omega+cfg_k)/4) dwords, addresses 0,1,2,... consecutively.
REQ-026 SHALL buffer at most 7 index bytes internally; emit a dword whenever 4 or more bytes are pending (at most one write per cycle).
REQ-027 SHALL append index bytes in the same cycle the beat is accepted; first write no earlier than 1 cycle after the 4th byte is accepted.
REQ-028 SHALL keep a 12-bit running hint total; set invalid_h when the total exceeds cfg_omega.
REQ-029 SHALL, once the total reaches cfg_omega, discard further index bytes (no stream byte beyond cfg_omega-1 gets index data) while continuing to consume beats and count.
REQ-030 SHALL in TAIL generate zero-fill, count and pad bytes at up to 4 bytes per cycle, merged behind leftover buffer bytes.
REQ-031 SHALL move TAIL->DONE after the final dword write; DONE pulses done for 1 cycle and returns to IDLE.
REQ-032 SHALL hold invalid_h until the next start, zeroize or reset.
REQ-033 SHALL ignore start outside IDLE and hint_valid outside ACCUM.
REQ-034 SHALL keep reg_wrdata=0 when reg_wren=0.

Reset
REQ-035 SHALL on reset_n low or zeroize: state IDLE; hint_ready, reg_wren, reg_wr_addr, reg_wrdata, invalid_h, done = 0; buffer, counters, latched config cleared.
REQ-036 SHALL abort any operation on zeroize mid-run without emitting further writes or done.

Verification
REQ-037 SHALL test all-zero hints, cfg_k=8, omega=75: 21 dwords written, bytes 0..74 = 0, bytes 75..82 = 0, byte 83 = 0, done once.
REQ-038 SHALL test hints at poly0 coeffs 3,255 and poly3 coeff 0, cfg_k=4, omega=80: h[0..2]=03,FF,00; h[80..83]=02,02,02,03; 21 dwords.
REQ-039 SHALL test 76 hints with omega=75: invalid_h set at crossing beat, h[75..] counts saturate correctly, no index byte beyond position 74.
REQ-040 SHALL test cfg_k=6, omega=55, COEF_PER_CYC=1, and 2 with random hint_valid gaps: stream matches the reference model, addresses 0..15 contiguous.
REQ-041 SHALL test zeroize mid-ACCUM: next cycle all outputs 0; a fresh start produces a correct full run.
